// File: rtl/therm_rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// therm_rr_arb_pkg
// Shared types and helpers for the thermometer-mask round-robin arbiter.
// The helpers work on a fixed MAX_N-wide vector. Callers zero-extend their
// N-bit operands and truncate the results back to N bits.
// -----------------------------------------------------------------------------
package therm_rr_arb_pkg;

  localparam int MAX_N   = 64;
  localparam int MAX_IDW = 6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Isolate the lowest set bit (two's-complement trick). Zero in gives zero out.
  function automatic logic [MAX_N-1:0] lowest_set(input logic [MAX_N-1:0] v);
    return v & (~v + 64'd1);
  endfunction

  // Binary index of a one-hot vector. An all-zero input returns 0.
  function automatic logic [MAX_IDW-1:0] onehot_to_bin(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] b;
    b = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (oh[k]) b = b | MAX_IDW'(k);
    end
    return b;
  endfunction

  // Priority mask after granting idx: bits above idx set, bits 0..idx clear.
  function automatic logic [MAX_N-1:0] gen_mask(input logic [MAX_IDW-1:0] idx);
    logic [MAX_N-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_N; k++) begin
      m[k] = (k > int'(idx));
    end
    return m;
  endfunction

endpackage

// File: rtl/therm_rr_arb_if.sv
// -----------------------------------------------------------------------------
// therm_rr_arb_if
// Request/grant bundle of the arbiter.
//   i_req      : request vector, bit k = requester k
//   i_done     : current owner releases the resource
//   o_gnt_vld  : a grant is active
//   o_gnt      : one-hot grant, zero when idle
//   o_gnt_id   : binary index of the granted requester, zero when idle
//   o_mask_err : sticky flag, the priority mask left thermometer form
// The slave modport is the arbiter side. The master modport is the requester
// side.
// -----------------------------------------------------------------------------
interface therm_rr_arb_if #(
  parameter int N = 8
) ();
  localparam int IDW = $clog2(N);

  logic [N-1:0]   i_req;
  logic           i_done;
  logic           o_gnt_vld;
  logic [N-1:0]   o_gnt;
  logic [IDW-1:0] o_gnt_id;
  logic           o_mask_err;

  modport slave (
    input  i_req, i_done,
    output o_gnt_vld, o_gnt, o_gnt_id, o_mask_err
  );

  modport master (
    output i_req, i_done,
    input  o_gnt_vld, o_gnt, o_gnt_id, o_mask_err
  );
endinterface

// File: rtl/therm_rr_arb_mask_chk.sv
// -----------------------------------------------------------------------------
// therm_rr_arb_mask_chk
// Purely combinational shape check of the priority mask.
//   mask_i     : N-bit priority mask
//   is_legal_o : 1 when the mask has the form 1..10..0 (MSB-aligned), which
//                includes all-ones and all-zeros
// The complement of a legal mask is a block of low ones. Adding one to such a
// block clears every bit of it, so the AND with the complement is zero.
// -----------------------------------------------------------------------------
module therm_rr_arb_mask_chk #(
  parameter int N = 8
) (
  input  logic [N-1:0] mask_i,
  output logic         is_legal_o
);
  logic [N-1:0] inv;

  always_comb begin
    inv        = ~mask_i;
    is_legal_o = (((inv + N'(1)) & inv) == '0);
  end
endmodule

// File: rtl/therm_rr_arb.sv
// -----------------------------------------------------------------------------
// therm_rr_arb
// Round-robin arbiter for N requesters sharing one resource. Rotating priority
// is held as a thermometer mask. The grant is registered and held until the
// owner raises i_done. Hand-over to the next requester happens back to back.
//   clk  : clock
//   arst : asynchronous, active-high reset
//   bus  : therm_rr_arb_if.slave (requests, done, grant outputs, mask error)
// -----------------------------------------------------------------------------
module therm_rr_arb
  import therm_rr_arb_pkg::*;
#(
  parameter int N             = 8,
  parameter bit P_MASK_CHK_EN = 1'b1
) (
  input  logic          clk,
  input  logic          arst,
  therm_rr_arb_if.slave bus
);
  localparam int IDW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   mask_q,  mask_d;
  logic [N-1:0]   gnt_q,   gnt_d;
  logic [IDW-1:0] id_q,    id_d;

  logic [MAX_N-1:0]   req_w, msk_w, hit_w, win_w;
  logic [MAX_IDW-1:0] win_idx;
  logic               any_req;
  logic               load;
  logic               rel;

  // Arbitration: masked requests win first. When none remain, fall back to the
  // raw requests, which wraps priority back to requester 0.
  always_comb begin
    req_w   = MAX_N'(bus.i_req);
    msk_w   = MAX_N'(mask_q);
    hit_w   = req_w & msk_w;
    any_req = |bus.i_req;
    win_w   = (hit_w != '0) ? lowest_set(hit_w) : lowest_set(req_w);
    win_idx = onehot_to_bin(win_w);
  end

  // State register; grant and mask registers share the same reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      mask_q  <= '1;
      gnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
    end
  end

  // Next-state logic. i_done is ignored while IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (bus.i_done && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic. A grant is loaded from IDLE, or on completion with
  // requests pending. The mask only moves when a grant is loaded.
  always_comb begin
    load   = any_req && ((state_q == IDLE) || bus.i_done);
    rel    = (state_q == BUSY) && bus.i_done && !any_req;
    gnt_d  = gnt_q;
    id_d   = id_q;
    mask_d = mask_q;
    if (load) begin
      gnt_d  = N'(win_w);
      id_d   = IDW'(win_idx);
      mask_d = N'(gen_mask(win_idx));
    end else if (rel) begin
      gnt_d  = '0;
      id_d   = '0;
    end
  end

  assign bus.o_gnt_vld = (state_q == BUSY);
  assign bus.o_gnt     = gnt_q;
  assign bus.o_gnt_id  = id_q;

  generate
    if (P_MASK_CHK_EN) begin : g_chk
      logic mask_legal;
      logic mask_err_q;

      therm_rr_arb_mask_chk #(.N(N)) u_mask_chk (
        .mask_i     (mask_q),
        .is_legal_o (mask_legal)
      );

      // Sticky until reset; arbitration is not affected by it.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) mask_err_q <= 1'b0;
        else      mask_err_q <= mask_err_q | ~mask_legal;
      end

      assign bus.o_mask_err = mask_err_q;
    end else begin : g_nochk
      assign bus.o_mask_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_therm_rr_arb.sv
module tb_therm_rr_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  therm_rr_arb_if #(.N(N)) bus ();

  therm_rr_arb #(.N(N), .P_MASK_CHK_EN(1'b1)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       vld;
    int         id;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input int id, input logic err);
    logic [3:0] eg;
    eg = vld ? 4'(1 << id) : 4'b0000;
    check({tag, ".vld"}, 32'(bus.o_gnt_vld), 32'(vld));
    check({tag, ".id"},  32'(bus.o_gnt_id),  vld ? 32'(id) : 32'd0);
    check({tag, ".gnt"}, 32'(bus.o_gnt),     32'(eg));
    check({tag, ".err"}, 32'(bus.o_mask_err), 32'(err));
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    bus.i_req  = r;
    bus.i_done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst       = 1'b1;
    bus.i_req  = '0;
    bus.i_done = 1'b0;
    #1;
    check_out("reset", 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  // Reference model: rotating start pointer; the first requester at or after
  // the pointer wins, otherwise the first requester from index 0.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = p; i < N; i++) if (r[i]) return i;
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  initial begin
    int   ptr;
    int   owner;
    bit   busy;
    logic [3:0] r;
    logic d;

    arst       = 1'b1;
    bus.i_req  = '0;
    bus.i_done = 1'b0;

    // Test 1: full request, done every cycle -> ids 0,1,2,3,0,1
    tbl.push_back('{4'b1111, 1'b0, 1'b1, 0});
    tbl.push_back('{4'b1111, 1'b1, 1'b1, 1});
    tbl.push_back('{4'b1111, 1'b1, 1'b1, 2});
    tbl.push_back('{4'b1111, 1'b1, 1'b1, 3});
    tbl.push_back('{4'b1111, 1'b1, 1'b1, 0});
    tbl.push_back('{4'b1111, 1'b1, 1'b1, 1});
    // Test 4: owner 1 done with 0011 -> id 0, no bubble
    tbl.push_back('{4'b0011, 1'b1, 1'b1, 0});
    // go idle, then test 2: single request held without req
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 0});
    tbl.push_back('{4'b0100, 1'b0, 1'b1, 2});
    for (int i = 0; i < 5; i++) tbl.push_back('{4'b0000, 1'b0, 1'b1, 2});
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 0});
    // Test 3: grant 3 (mask all zero), wrap to 1, then 3
    tbl.push_back('{4'b1000, 1'b0, 1'b1, 3});
    tbl.push_back('{4'b1010, 1'b1, 1'b1, 1});
    tbl.push_back('{4'b1010, 1'b1, 1'b1, 3});
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 0});
    // done while idle is ignored
    tbl.push_back('{4'b0000, 1'b1, 1'b0, 0});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].done);
      check_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].id, 1'b0);
    end

    // Test 5: reset mid-grant, restart from requester 0
    do_reset();
    step(4'b0100, 1'b0);
    check_out("t5.pre", 1'b1, 2, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    check_out("t5.async", 1'b0, 0, 1'b0);
    @(negedge clk);
    bus.i_req  = 4'b0110;
    bus.i_done = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    check_out("t5.post", 1'b1, 1, 1'b0);

    // Test 6: corrupt the mask while idle; the error is sticky until reset
    step(4'b0000, 1'b1);
    check_out("t6.idle", 1'b0, 0, 1'b0);
    @(negedge clk);
    bus.i_req  = 4'b0000;
    bus.i_done = 1'b0;
    force dut.mask_q = 4'b1010;
    #1;
    check("t6.err_before", 32'(bus.o_mask_err), 32'd0);
    @(posedge clk);
    #1;
    check("t6.err_set", 32'(bus.o_mask_err), 32'd1);
    @(negedge clk);
    release dut.mask_q;
    step(4'b1111, 1'b0);
    check("t6.vld1", 32'(bus.o_gnt_vld), 32'd1);
    check("t6.err1", 32'(bus.o_mask_err), 32'd1);
    step(4'b1111, 1'b1);
    check("t6.vld2", 32'(bus.o_gnt_vld), 32'd1);
    check("t6.err2", 32'(bus.o_mask_err), 32'd1);
    step(4'b0000, 1'b1);
    check("t6.err3", 32'(bus.o_mask_err), 32'd1);
    do_reset();

    // Randomized traffic against the reference model
    ptr   = 0;
    owner = 0;
    busy  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 2) != 0);
      step(r, d);
      if (!busy || d) begin
        if (r != 4'b0000) begin
          owner = pick(r, ptr);
          busy  = 1'b1;
          ptr   = owner + 1;
        end else begin
          busy = 1'b0;
        end
      end
      check_out($sformatf("rnd%0d", c), busy, busy ? owner : 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
